// File: rtl/systolic_matmul_stream.sv
// -----------------------------------------------------------------------------
// systolic_matmul_stream
//
// Output-stationary N x N systolic matrix multiplier, C = A x B.
// Operands are fetched from two single-cycle-latency memory read ports
// starting at caller-supplied base addresses. Results leave as a raster-order
// (row-major) stream with valid/ready handshake.
//
// Sequence: IDLE -> FETCH (N+1 cycles) -> COMPUTE (3N-2 cycles)
//           -> DRAIN (N*N accepted beats) -> DONE (1 cycle) -> IDLE
//
// Optional feature: define SYSTOLIC_SAT_EN to make every accumulate step
// saturate (signed or unsigned range) and raise the sticky sat_flag.
// Without it accumulators wrap and sat_flag is tied low.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin an operation (sampled only in IDLE)
//   signed_mode       1 = two's-complement operands (captured at start)
//   a_base, b_base    operand base addresses (captured at start)
//   a_addr / a_rdata  A column k at a_base+k; element r at [r*DW +: DW]
//   b_addr / b_rdata  B row k at b_base+k;    element c at [c*DW +: DW]
//   res_valid/ready   result stream handshake
//   res_data          C[res_row][res_col]
//   res_last          final beat, C[N-1][N-1]
//   busy              high in every state except IDLE
//   done              one-cycle pulse in DONE
//   sat_flag          sticky saturation indicator, cleared at start
// -----------------------------------------------------------------------------
module systolic_matmul_stream #(
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int ADDR_WIDTH = 4,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [ADDR_WIDTH-1:0]   a_base,
  input  logic [ADDR_WIDTH-1:0]   b_base,
  output logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [N*DATA_WIDTH-1:0] a_rdata,
  output logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [N*DATA_WIDTH-1:0] b_rdata,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_WIDTH-1:0]    res_data,
  output logic [IDX_W-1:0]        res_row,
  output logic [IDX_W-1:0]        res_col,
  output logic                    res_last,
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(3 * N + 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(N);
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] COMP_LAST  = CNT_W'(3 * N - 3);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);

  typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    sm_reg;
  logic [N*DATA_WIDTH-1:0] a_buf_reg [N];   // word k = column k of A
  logic [N*DATA_WIDTH-1:0] b_buf_reg [N];   // word k = row k of B
  logic [DATA_WIDTH-1:0]   a_pipe_reg [N][N];
  logic [DATA_WIDTH-1:0]   b_pipe_reg [N][N];
  logic [ACC_WIDTH-1:0]    acc_reg [N][N];

  logic [DATA_WIDTH-1:0]   a_left [N];
  logic [DATA_WIDTH-1:0]   b_top [N];
  logic [DATA_WIDTH-1:0]   a_fwd [N][N];
  logic [DATA_WIDTH-1:0]   b_fwd [N][N];
  logic [ACC_WIDTH-1:0]    acc_next [N][N];
  logic [CNT_W-1:0]        cap_cnt;
  logic [IDX_W-1:0]        nxt_row, nxt_col;

  assign cap_cnt = cnt_reg - CNT_W'(1);
  assign nxt_col = (res_col == IDX_LAST) ? '0 : res_col + IDX_W'(1);
  assign nxt_row = (res_col == IDX_LAST) ? res_row + IDX_W'(1) : res_row;

  // Edge injection: row i of A and column i of B both enter i cycles late,
  // so both use element index k = cnt - i inside the window [i, i+N).
  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    logic [CNT_W-1:0] k_idx;
    logic             win;
    assign k_idx = cnt_reg - CNT_W'(gi);
    assign win   = (cnt_reg >= CNT_W'(gi)) && (cnt_reg < CNT_W'(gi + N));
    assign a_left[gi] = win ? a_buf_reg[k_idx[IDX_W-1:0]][gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign b_top[gi]  = win ? b_buf_reg[k_idx[IDX_W-1:0]][gi*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

`ifdef SYSTOLIC_SAT_EN
  logic [N*N-1:0] pe_sat;
  logic           sat_flag_reg;
  assign sat_flag = sat_flag_reg;
`else
  assign sat_flag = 1'b0;
`endif

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in;
      logic [PW-1:0]         a_x, b_x, prod;
      logic [ACC_WIDTH-1:0]  prod_x;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_left[gi];
      end else begin : g_a_pipe
        assign a_in = a_pipe_reg[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = b_top[gj];
      end else begin : g_b_pipe
        assign b_in = b_pipe_reg[gi-1][gj];
      end

      assign a_fwd[gi][gj] = a_in;
      assign b_fwd[gi][gj] = b_in;

      // The low 2*DW bits of the product of extended operands are exact in
      // both signed and unsigned interpretation.
      assign a_x  = {{DATA_WIDTH{sm_reg & a_in[DATA_WIDTH-1]}}, a_in};
      assign b_x  = {{DATA_WIDTH{sm_reg & b_in[DATA_WIDTH-1]}}, b_in};
      assign prod = a_x * b_x;

      if (ACC_WIDTH > PW) begin : g_ext
        assign prod_x = {{(ACC_WIDTH-PW){sm_reg & prod[PW-1]}}, prod};
      end else begin : g_noext
        assign prod_x = prod;
      end

`ifdef SYSTOLIC_SAT_EN
      // One guard bit exposes overflow: signed overflow when the guard and
      // sign bits disagree, unsigned overflow on carry-out.
      logic [ACC_WIDTH:0] sum_w;
      logic               ovf;
      assign sum_w = {sm_reg & acc_reg[gi][gj][ACC_WIDTH-1], acc_reg[gi][gj]}
                   + {sm_reg & prod_x[ACC_WIDTH-1], prod_x};
      assign ovf   = sm_reg ? (sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1]) : sum_w[ACC_WIDTH];
      assign pe_sat[gi*N+gj] = ovf;
      assign acc_next[gi][gj] = !ovf ? sum_w[ACC_WIDTH-1:0] :
                                !sm_reg ? {ACC_WIDTH{1'b1}} :
                                sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                                   {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
      assign acc_next[gi][gj] = acc_reg[gi][gj] + prod_x;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      sm_reg    <= 1'b0;
      a_addr    <= '0;
      b_addr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SYSTOLIC_SAT_EN
      sat_flag_reg <= 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
        a_buf_reg[i] <= '0;
        b_buf_reg[i] <= '0;
        for (int j = 0; j < N; j++) begin
          acc_reg[i][j]    <= '0;
          a_pipe_reg[i][j] <= '0;
          b_pipe_reg[i][j] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sm_reg    <= signed_mode;
            a_addr    <= a_base;
            b_addr    <= b_base;
            cnt_reg   <= '0;
            busy      <= 1'b1;
`ifdef SYSTOLIC_SAT_EN
            sat_flag_reg <= 1'b0;
`endif
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          // Read data lags the address by one cycle: capture word cnt-1.
          if (cnt_reg != '0) begin
            a_buf_reg[cap_cnt[IDX_W-1:0]] <= a_rdata;
            b_buf_reg[cap_cnt[IDX_W-1:0]] <= b_rdata;
          end
          if (cnt_reg == FETCH_LAST) begin
            cnt_reg   <= '0;
            state_reg <= COMPUTE;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                acc_reg[i][j]    <= '0;
                a_pipe_reg[i][j] <= '0;
                b_pipe_reg[i][j] <= '0;
              end
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg < ADDR_LAST) begin
              a_addr <= a_addr + ADDR_WIDTH'(1);
              b_addr <= b_addr + ADDR_WIDTH'(1);
            end else begin
              a_addr <= '0;
              b_addr <= '0;
            end
          end
        end
        COMPUTE: begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              acc_reg[i][j]    <= acc_next[i][j];
              a_pipe_reg[i][j] <= a_fwd[i][j];
              b_pipe_reg[i][j] <= b_fwd[i][j];
            end
          end
`ifdef SYSTOLIC_SAT_EN
          if (|pe_sat) sat_flag_reg <= 1'b1;
`endif
          if (cnt_reg == COMP_LAST) begin
            // C[0][0] finished long ago; only the corner PE can still be
            // adding a non-zero term, so acc_next is the settled value.
            cnt_reg   <= '0;
            state_reg <= DRAIN;
            res_valid <= 1'b1;
            res_data  <= acc_next[0][0];
            res_row   <= '0;
            res_col   <= '0;
            res_last  <= (N == 1);
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (res_last) begin
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              res_data  <= '0;
              res_row   <= '0;
              res_col   <= '0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              res_row  <= nxt_row;
              res_col  <= nxt_col;
              res_data <= acc_reg[nxt_row][nxt_col];
              res_last <= (nxt_row == IDX_LAST) && (nxt_col == IDX_LAST);
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// -----------------------------------------------------------------------------
// tb_systolic_matmul_stream
//
// Directed-vector bench for systolic_matmul_stream at N=3, DW=8, ACC=16.
// 2x2 cases are embedded in the top-left corner of zero-padded 3x3 operands.
// Expected C values are hand-computed constants; saturation cases select the
// SYSTOLIC_SAT_EN or wrapping result depending on the build.
// -----------------------------------------------------------------------------
module tb_systolic_matmul_stream;

  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int ACC = 16;
  localparam int AW  = 4;

`ifdef SYSTOLIC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start, signed_mode, res_ready;
  logic [AW-1:0]   a_base, b_base, a_addr, b_addr;
  logic [N*DW-1:0] a_rdata, b_rdata;
  logic            res_valid, res_last, busy, done, sat_flag;
  logic [ACC-1:0]  res_data;
  logic [1:0]      res_row, res_col;

  logic [N*DW-1:0] mem_a [16];
  logic [N*DW-1:0] mem_b [16];
  logic [ACC-1:0]  exp_c [9];

  int n_vec;
  int n_err;

  systolic_matmul_stream #(
    .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a_base(a_base), .b_base(b_base),
    .a_addr(a_addr), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .res_last(res_last),
    .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  // Single-cycle-latency operand memories.
  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic load(input logic [3:0] ab, input logic [3:0] bb,
                      input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                      input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2);
    mem_a[ab]             = a0;
    mem_a[4'(ab + 4'd1)]  = a1;
    mem_a[4'(ab + 4'd2)]  = a2;
    mem_b[bb]             = b0;
    mem_b[4'(bb + 4'd1)]  = b1;
    mem_b[4'(bb + 4'd2)]  = b2;
  endtask

  task automatic set_exp(input logic [143:0] v);
    for (int i = 0; i < 9; i++) exp_c[i] = v[(8-i)*16 +: 16];
  endtask

  // One full operation: start, watch every cycle, check each accepted beat,
  // stall stability, done placement and final flags.
  task automatic run(input string tag, input logic sm, input logic [3:0] ab,
                     input logic [3:0] bb, input bit toggle, input bit poke,
                     input logic exp_sat);
    int beat, first_cyc, done_cyc, done_cnt;
    logic held;
    logic [20:0] held_v;
    beat = 0; first_cyc = -1; done_cyc = -1; done_cnt = 0; held = 1'b0; held_v = '0;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; a_base = ab; b_base = bb; res_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; signed_mode = ~sm; a_base = ~ab; b_base = ~bb;
    for (int cyc = 1; cyc < 150; cyc++) begin
      @(negedge clk);
      res_ready = toggle ? (cyc % 3 == 0) : 1'b1;
      if (cyc == 1) begin
        check({tag, "_busy_rise"}, 40'(busy), 40'd1);
        check({tag, "_sat_clear"}, 40'(sat_flag), 40'd0);
      end
      if (poke && cyc == first_cyc + 1) start = 1'b0;
      if (res_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held) check({tag, "_stall_hold"}, 40'({res_data, res_row, res_col, res_last}), 40'(held_v));
        if (res_ready) begin
          $display("%s beat %0d C[%0d][%0d]=0x%0h last=%0b", tag, beat, res_row, res_col, res_data, res_last);
          if (beat < 9)
            check($sformatf("%s_c%0d%0d", tag, beat / 3, beat % 3),
                  40'({res_data, res_row, res_col, res_last}),
                  40'({exp_c[beat], 2'(beat / 3), 2'(beat % 3), beat == 8}));
          else
            check({tag, "_extra_beat"}, 40'(beat), 40'd8);
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_v = {res_data, res_row, res_col, res_last};
        end
        if (poke && cyc == first_cyc) start = 1'b1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check({tag, "_done_after_last"}, 40'(beat), 40'd9);
      end
      if (done_cnt > 0 && !busy) break;
      @(posedge clk);
    end
    start = 1'b0;
    check({tag, "_beats"}, 40'(beat), 40'd9);
    check({tag, "_done_pulses"}, 40'(done_cnt), 40'd1);
    check({tag, "_sat_flag"}, 40'(sat_flag), 40'(exp_sat));
    check({tag, "_first_beat_cyc"}, 40'(first_cyc), 40'd12);
    check({tag, "_done_cyc"}, 40'(done_cyc), toggle ? 40'd37 : 40'd21);
    repeat (2) @(negedge clk);
    check({tag, "_idle_after"}, 40'(busy), 40'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; res_ready = 1'b0;
    a_base = '0; b_base = '0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          40'({a_addr, b_addr, res_valid, res_data, res_row, res_col, res_last, busy, done, sat_flag}), 40'd0);
    rst_n = 1'b1;

    // Unsigned 2x2 [[1,2],[3,4]] x [[5,6],[7,8]], bases wrap past 15.
    load(4'd14, 4'd15, {8'd0, 8'd3, 8'd1}, {8'd0, 8'd4, 8'd2}, 24'd0,
                       {8'd0, 8'd6, 8'd5}, {8'd0, 8'd8, 8'd7}, 24'd0);
    set_exp({16'd19, 16'd22, 16'd0, 16'd43, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0});
    run("u2x2", 1'b0, 4'd14, 4'd15, 1'b0, 1'b0, 1'b0);

    // Signed [[-1,2],[3,-4]] x identity.
    load(4'd0, 4'd4, {8'h00, 8'h03, 8'hFF}, {8'h00, 8'hFC, 8'h02}, 24'd0,
                     24'h000001, 24'h000100, 24'h010000);
    set_exp({16'hFFFF, 16'd2, 16'd0, 16'd3, 16'hFFFC, 16'd0, 16'd0, 16'd0, 16'd0});
    run("s2x2", 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0);

    // Signed -128 row/column: 3 x 16384 overflows a 16-bit accumulator.
    load(4'd7, 4'd10, 24'h000080, 24'h000080, 24'h000080,
                      24'h000080, 24'h000080, 24'h000080);
    set_exp({(SAT ? 16'h7FFF : 16'hC000), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    run("s_ovf", 1'b1, 4'd7, 4'd10, 1'b0, 1'b0, SAT);

    // Unsigned 255 row/column: 3 x 65025 = 195075.
    load(4'd7, 4'd10, 24'h0000FF, 24'h0000FF, 24'h0000FF,
                      24'h0000FF, 24'h0000FF, 24'h0000FF);
    set_exp({(SAT ? 16'hFFFF : 16'hFA03), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    run("u_ovf", 1'b0, 4'd7, 4'd10, 1'b0, 1'b0, SAT);

    // Full 3x3 with res_ready pattern 1,0,0,1,...
    load(4'd1, 4'd12, {8'd7, 8'd4, 8'd1}, {8'd8, 8'd5, 8'd2}, {8'd9, 8'd6, 8'd3},
                      {8'd7, 8'd8, 8'd9}, {8'd4, 8'd5, 8'd6}, {8'd1, 8'd2, 8'd3});
    set_exp({16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90});
    run("stall3x3", 1'b0, 4'd1, 4'd12, 1'b1, 1'b0, 1'b0);

    // start pulsed during DRAIN must be ignored.
    load(4'd14, 4'd15, {8'd0, 8'd3, 8'd1}, {8'd0, 8'd4, 8'd2}, 24'd0,
                       {8'd0, 8'd6, 8'd5}, {8'd0, 8'd8, 8'd7}, 24'd0);
    set_exp({16'd19, 16'd22, 16'd0, 16'd43, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0});
    run("poke", 1'b0, 4'd14, 4'd15, 1'b0, 1'b1, 1'b0);

    // Reset for one cycle mid-COMPUTE, then restart with new bases.
    load(4'd5, 4'd9, {8'h00, 8'h03, 8'hFF}, {8'h00, 8'hFC, 8'h02}, 24'd0,
                     24'h000001, 24'h000100, 24'h010000);
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; a_base = 4'd5; b_base = 4'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 40'(busy), 40'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs",
          40'({a_addr, b_addr, res_valid, res_data, res_row, res_col, res_last, busy, done, sat_flag}), 40'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", 40'(busy), 40'd0);

    load(4'd10, 4'd2, {8'd7, 8'd4, 8'd1}, {8'd8, 8'd5, 8'd2}, {8'd9, 8'd6, 8'd3},
                      {8'd7, 8'd8, 8'd9}, {8'd4, 8'd5, 8'd6}, {8'd1, 8'd2, 8'd3});
    set_exp({16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90});
    run("after_rst", 1'b0, 4'd10, 4'd2, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_stream.md
# systolic_matmul_stream

Parametrised output-stationary systolic matrix multiplier computing C = A × B for N×N operands with configurable element and accumulator widths and a runtime signed/unsigned mode. It fetches operands over two single-cycle-latency memory read ports from caller-supplied base addresses. It returns results as a backpressured raster-order stream instead of a flat result array. It is the next-generation matrix engine of the multiplier datapath.

## Interface
Parameters:
- `N`, 3 — array dimension; N ≥ 1.
- `DATA_WIDTH`, 8 — operand element width.
- `ACC_WIDTH`, 20 — accumulator/result width; must be ≥ 2·DATA_WIDTH.
- `ADDR_WIDTH`, 4 — operand memory address width.
- Derived: `IDX_W` = max(1, $clog2(N)).

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — synchronous, active-low reset.
- `start` in 1 — begin operation; sampled only in IDLE.
- `signed_mode` in 1 — 1 = two's-complement operands; captured at start.
- `a_base`, `b_base` in ADDR_WIDTH — operand base addresses; captured at start.
- `a_addr` out ADDR_WIDTH — A column address; word k holds column k, element r at bits [r·DW +: DW].
- `a_rdata` in N·DATA_WIDTH — A read data, valid 1 cycle after `a_addr`.
- `b_addr` out ADDR_WIDTH — B row address; word k holds row k, element c at bits [c·DW +: DW].
- `b_rdata` in N·DATA_WIDTH — B read data, valid 1 cycle after `b_addr`.
- `res_valid` out 1; `res_ready` in 1 — result stream handshake.
- `res_data` out ACC_WIDTH — C[row][col].
- `res_row`, `res_col` out IDX_W — element index.
- `res_last` out 1 — high on the final beat, C[N-1][N-1].
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — high for exactly one cycle, in DONE.
- `sat_flag` out 1 — sticky saturation indicator; cleared at start.

## Operation
- States: IDLE → FETCH → COMPUTE → DRAIN → DONE → IDLE.
- IDLE: outputs idle; on `start`, capture `signed_mode`, bases; clear `sat_flag` → FETCH.
- FETCH, N+1 cycles:
  - Cycle k (0..N-1) drives a_addr = a_base+k and b_addr = b_base+k; addresses wrap modulo 2^ADDR_WIDTH.
  - Cycles 1..N capture returned words into local A/B buffers.
  - After the last capture, all N² accumulators are cleared → COMPUTE.
- COMPUTE, 3N-2 cycles:
  - A row i is injected at the left edge skewed by i cycles; B column j is injected at the top skewed by j cycles.
  - PE(i,j) forwards A right and B down, and accumulates acc += a·b.
  - Zeros are injected outside valid skew windows. → DRAIN.
- DRAIN: N² beats in raster order (row-major), row 0 col 0 first.
  - `res_valid` high; data and indices are held stable until `res_valid && res_ready`.
  - After the beat with `res_last` → DONE.
- DONE: one cycle, `done`=1 → IDLE.
- Arithmetic:
  - Operands are sign-extended (signed_mode=1) or zero-extended to 2·DW.
  - The product is extended to ACC_WIDTH the same way.
  - Default: wrap modulo 2^ACC_WIDTH.
- `start` while busy is ignored; no queueing.
- `a_rdata`/`b_rdata` are ignored outside FETCH capture cycles.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0 (addresses, res_*, busy, done, sat_flag); accumulators and buffers cleared. Applies mid-operation in any state, and any in-flight stream beat is dropped.
- Cycle 0 = `start` seen in IDLE. FETCH occupies cycles 1..N+1, COMPUTE cycles N+2..4N-1, and DRAIN begins at cycle 4N.
- With res_ready tied 1: one beat per cycle, last beat at 4N+N²-1, `done` at 4N+N², back in IDLE at 4N+N²+1. For N=3: first beat at cycle 12, `done` at cycle 21.
- Each cycle of res_ready=0 during DRAIN adds one cycle and does not corrupt data.
- `busy` rises in the cycle after `start` and falls when the state returns to IDLE.

## Configuration
- `SYSTOLIC_SAT_EN` defined:
  - Each accumulate step clamps to [-2^(ACC-1), 2^(ACC-1)-1] in signed mode, or [0, 2^ACC-1] in unsigned mode.
  - Any clamp sets `sat_flag`, which stays set until the next start or reset.
- Undefined: accumulators wrap and `sat_flag` is tied 0.

## Test plan
- N=2, DW=8, ACC=20, unsigned; A=[[1,2],[3,4]], B=[[5,6],[7,8]], res_ready=1 → stream 19,22,43,50; indices (0,0),(0,1),(1,0),(1,1); res_last on 50; done at cycle 12.
- N=2, signed; A=[[-1,2],[3,-4]], B=identity → stream -1,2,3,-4.
- N=3, DW=8, ACC=16, signed; A row 0 and B col 0 all -128 → C[0][0] = 32767 with SAT_EN and sat_flag=1; -16384 without SAT_EN. Unsigned, all 255 → C[0][0] = 65535 with SAT_EN, 64003 without.
- N=3, res_ready toggling 1,0,0,1… → 9 beats in order with values stable across stalls; done only after res_last is accepted.
- rst_n=0 for one cycle mid-COMPUTE, then restart with new bases → outputs 0 after reset; second run produces correct results.
- start pulsed during DRAIN → ignored; exactly N² beats and one done pulse.
